logic_mux_rr: RTL
=================

Name: logic_mux_rr

Overview:
- Parametrised, multi-channel, registered successor to the single-bit mux-based logic cell.
- Each of N channels computes y = a ? b : (b | ~c) bitwise over WIDTH bits.
- A round-robin or fixed-select arbiter picks one valid channel per cycle into a single output register with a valid/ready handshake.
- Sits between per-channel producers and one downstream consumer; also counts completed transfers.

Parameters:
- N, 4, number of input channels; N >= 2 is required.
- WIDTH, 8, datapath width per channel.
- CNT_W, 16, width of the transfer counter.
- SEL_W, $clog2(N), derived; width of channel index fields. Not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_rr  in  1  1 = round-robin arbitration, 0 = fixed select.
- fix_sel  in  SEL_W  channel used when mode_rr=0.
- in_valid  in  N  per-channel request.
- in_ready  out  N  per-channel accept; combinational.
- in_a  in  N  per-channel mux select.
- in_b  in  N*WIDTH  per-channel operand b; channel i occupies bits [i*WIDTH +: WIDTH].
- in_c  in  N*WIDTH  per-channel operand c; same packing as in_b.
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  registered result.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- xfer_cnt  out  CNT_W  count of output handshakes, saturating.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, xfer_cnt=0, rr_ptr=N-1, so channel 0 has first priority.
- Per-channel function is purely combinational: f_i = in_a[i] ? in_b_i : (in_b_i | ~in_c_i), bitwise.
- load_en = ~out_valid | out_ready. The output stage is a single entry that accepts a new word in the same cycle the old one drains; there is no bubble.
- Eligibility:
  - mode_rr=1: every channel with in_valid=1 is eligible.
  - mode_rr=0: only channel fix_sel, and only if its in_valid=1.
  - fix_sel >= N: no channel is eligible.
- RR grant: the first eligible index scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo N.
- in_ready[g]=1 only when load_en=1, some channel is eligible, and g is the granted index. All other in_ready bits are 0.
- in_ready never depends on in_valid of its own channel in fixed mode beyond eligibility. Producers must not rely on in_ready before asserting in_valid.
- On an accept (in_valid[g] & in_ready[g]):
  - out_data <= f_g, out_chan <= g, out_valid <= 1, rr_ptr <= g.
  - rr_ptr is also updated in fixed mode, so round-robin resumes after the last served channel.
- No accept and out_ready=1: out_valid <= 0; out_data and out_chan hold their stale values.
- out_valid=1 and out_ready=0: out_data and out_chan are held stable.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle with out_ready held high.
- xfer_cnt increments on each out_valid & out_ready cycle and saturates at 2^CNT_W-1. It does not wrap.
- A mode_rr or fix_sel change takes effect in the same cycle's combinational arbitration. The entry already in the output register is unaffected.
- Reset mid-transfer: the pending output word is discarded, the counter clears, and the pointer returns to N-1.

Test Plan:
1. Reset, then mode_rr=1 and ch0 valid with a=0, b=0x01, c=0xF0 -> in_ready[0]=1; next cycle out_valid=1, out_data=0x0F, out_chan=0.
2. ch0 a=1, b=0x5A, c=0x00 -> out_data=0x5A. Same operands with a=0 -> out_data=0xFF.
3. All 4 channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,... over consecutive cycles; xfer_cnt=8 after 8 cycles.
4. mode_rr=0, fix_sel=2, all valid -> only in_ready[2] ever asserts. Switch to mode_rr=1 -> next grant is ch3.
5. out_ready=0 for 5 cycles with out_valid=1 -> out_data and out_chan stable and in_ready=0. Raise out_ready -> a new word loads in the same cycle.
6. Assert rst while out_valid=1 and xfer_cnt=3 -> out_valid=0 and xfer_cnt=0 immediately, before the next clk edge. With CNT_W=2, 5 transfers -> xfer_cnt=3 (saturated).

Source files
------------

// File: rtl/logic_mux_rr.sv
// N-channel bitwise mux cell (y = a ? b : b | ~c) with a round-robin or fixed-select arbiter
// feeding one registered valid/ready output stage and a saturating transfer counter.
module logic_mux_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_rr,
  input  logic [SEL_W-1:0]   fix_sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N*WIDTH-1:0] in_b,
  input  logic [N*WIDTH-1:0] in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_chan;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_rr_ptr;

  logic [N-1:0]       w_elig;
  logic               w_found;
  logic [SEL_W-1:0]   w_gnt;
  logic               w_load_en;
  logic               w_accept;
  logic               w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_c;
  logic [WIDTH-1:0]   w_f;

  // An out-of-range fix_sel never matches any index, so nothing is eligible.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_elig[i] = mode_rr ? in_valid[i] : (in_valid[i] && (32'(fix_sel) == i));
    end
  end

  always_comb begin
    int unsigned w_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % N;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = SEL_W'(w_idx);
      end
    end
  end

  assign w_load_en = ~r_out_valid | out_ready;
  assign w_accept  = w_load_en & w_found;

  assign w_a = in_a[w_gnt];
  assign w_b = in_b[w_gnt*WIDTH +: WIDTH];
  assign w_c = in_c[w_gnt*WIDTH +: WIDTH];
  assign w_f = w_a ? w_b : (w_b | ~w_c);

  always_comb begin
    in_ready = '0;
    if (w_accept) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_rr_ptr    <= SEL_W'(N - 1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_f;
      r_out_chan  <= w_gnt;
      r_rr_ptr    <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_out_valid && out_ready && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign xfer_cnt  = r_cnt;

endmodule
